mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit that acts as the initiator on the single-port `ram` interface (`write_enable`, `address`, `data_in`, `data_out`). It accepts byte, half, word and doubleword requests from the core over a valid/ready handshake. It performs aligned 64-bit RAM accesses, using read-modify-write for sub-doubleword stores, and returns sign- or zero-extended load data. It sits between the core's execute stage and `ram`.

## Interface
- MEM_RD_LAT, 1, cycles from `mem_address` presented (write_enable=0) to valid `mem_rdata`; legal 1..4
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=B, 1=H, 2=W, 3=D
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned (bits [8<<size-1:0] used)
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  misaligned request (see Configuration)
- mem_write_enable  out  1  to ram.write_enable
- mem_address  out  64  to ram.address; doubleword index = {3'b0, req_addr[63:3]}
- mem_wdata  out  64  to ram.data_in
- mem_rdata  in  64  from ram.data_out

## Operation
- All outputs registered. Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write_enable=0, mem_address=0, mem_wdata=0.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- IDLE: on req_valid&req_ready, latch request. Then:
  - load -> RD_WAIT
  - D store -> WRITE
  - B/H/W store -> RD_WAIT (RMW)
  - misaligned with check enabled -> RESP with err
- RD_WAIT: drives mem_address, write_enable=0. A down-counter of MEM_RD_LAT cycles runs, then mem_rdata is captured. Next state is RESP for a load, WRITE for a store.
- WRITE: mem_write_enable=1 for exactly one cycle. mem_wdata is either req_wdata (D), or the captured doubleword with lanes [off*8 +: 8<<size] replaced by the low store bytes, where off = addr[2:0]. Next state is RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Load extraction: field = captured >> (off*8), truncated to 8<<size bits, then extended per req_unsigned. D loads ignore req_unsigned.
- Byte lanes are little-endian; byte 0 is data[7:0].
- Only one request is outstanding at a time.
- Reset mid-operation:
  - next edge returns to IDLE and all outputs go to reset values
  - an in-flight request is dropped with no resp_valid
  - a pending RMW write is never issued

## Timing
- Handshake in cycle T; latched fields are stable until RESP exits.
- mem_address is valid from T+1.
- Load: resp_valid at T+2+MEM_RD_LAT.
- D store: mem_write_enable high in T+1; resp_valid at T+2.
- B/H/W store: read at T+1..T+MEM_RD_LAT, write at T+1+MEM_RD_LAT, resp_valid at T+2+MEM_RD_LAT.
- Misaligned with check enabled: resp_valid at T+1, no memory cycle.
- req_ready drops in T+1 and returns with the cycle after resp_valid. Back-to-back issue is therefore possible in the cycle following resp_valid.
- resp_rdata and resp_err are valid only while resp_valid=1.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - a request with addr[2:0] not a multiple of (1<<size) completes with resp_err=1 and resp_rdata=0
  - no RAM access occurs
- Not defined:
  - addr[2:0] is masked to natural alignment (low size bits cleared) before use
  - resp_err is tied 0

## Structure
- Package lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - FSM state enum
  - function size_bytes(size)
- Sub-module lsu_lane, purely combinational, holds both extract+extend (load) and merge (store) datapaths. It takes captured data, offset, size, unsigned and wdata, and returns load_data and merged_data.

## Test plan
- D store 0x1122334455667788 to addr 0x20 -> mem_write_enable one cycle with mem_address=4, mem_wdata=0x1122334455667788, resp_valid at T+2. A D load from 0x20 then returns 0x1122334455667788.
- Memory 0x20 holds 0x1122334455667788; B store 0xAA to 0x23 -> read then write 0x11223344AA667788, resp_valid at T+3 (MEM_RD_LAT=1).
- Memory 0x20 holds 0x00000000_8000FF80:
  - B load signed from 0x20 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80
  - H load signed from 0x22 -> 0xFFFFFFFFFFFF8000
  - W load unsigned from 0x20 -> 0x000000008000FF80
- W load from 0x22:
  - with LSU_MISALIGN_CHECK_EN -> resp_err=1 at T+1, mem_write_enable never asserted
  - without it -> treated as 0x20
- Reset asserted in the RD_WAIT cycle of a B store -> no write, no resp_valid, req_ready=1 next cycle; memory unchanged.
- MEM_RD_LAT=3, back-to-back loads held on req_valid -> second accepted the cycle after first resp_valid; each resp_valid 5 cycles after its acceptance.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - core request/response and ram initiator signals of the LSU
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_enable;
    logic [63:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    // master: the core plus ram environment around the LSU
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_write_enable, mem_address, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_write_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// rtl/mem_lsu_lane.sv - combinational byte-lane extract/extend and store merge
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  size_e       size,
    input  logic        uns,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged_data
);

    logic [5:0]  shamt;
    logic [63:0] field;
    logic [63:0] mask;

    assign shamt = {off, 3'b000};
    assign field = rdata >> shamt;

    always_comb begin
        mask      = '1;
        load_data = field;
        unique case (size)
            SZ_B: begin
                mask      = 64'h0000_0000_0000_00FF;
                load_data = {{56{~uns & field[7]}}, field[7:0]};
            end
            SZ_H: begin
                mask      = 64'h0000_0000_0000_FFFF;
                load_data = {{48{~uns & field[15]}}, field[15:0]};
            end
            SZ_W: begin
                mask      = 64'h0000_0000_FFFF_FFFF;
                load_data = {{32{~uns & field[31]}}, field[31:0]};
            end
            default: begin
                mask      = '1;
                load_data = field;
            end
        endcase
    end

    assign merged_data = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit driving a single-port 64-bit ram with RMW sub-word stores
// Optional LSU_MISALIGN_CHECK_EN: reject misaligned requests with resp_err instead of masking.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic      clk,
    input  logic      reset,
    mem_lsu_if.slave  bus
);

    state_e      state;
    state_e      state_next;
    logic        l_write;
    size_e       l_size;
    logic        l_uns;
    logic [2:0]  l_off;
    logic [63:0] l_wdata;
    logic [2:0]  cnt;

    size_e       req_size_e;
    logic [2:0]  align_mask;
    logic [2:0]  req_off;
    logic        misalign;
    logic        accept;
    logic        last_rd;
    logic [63:0] load_data;
    logic [63:0] merged_data;

    logic        ready_d;
    logic        valid_d;
    logic        we_d;
    logic [63:0] addr_d;
    logic [63:0] wdata_d;
    logic [63:0] rdata_d;
    logic        err_d;

    assign req_size_e = size_e'(bus.req_size);
    assign align_mask = 3'(size_bytes(req_size_e) - 4'd1);
    assign accept     = (state == IDLE) && bus.req_valid;
    assign last_rd    = (state == RD_WAIT) && (cnt == 3'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (bus.req_addr[2:0] & align_mask) != 3'd0;
    assign req_off  = bus.req_addr[2:0];
`else
    assign misalign = 1'b0;
    assign req_off  = bus.req_addr[2:0] & ~align_mask;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misalign) begin
                        state_next = RESP;
                    end else if (bus.req_write && (req_size_e == SZ_D)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 3'd1) begin
                    state_next = l_write ? WRITE : RESP;
                end
            end
            WRITE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // Loads hold the read one cycle longer than the RMW read so the extended result lands at T+2+LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            l_write <= 1'b0;
            l_size  <= SZ_B;
            l_uns   <= 1'b0;
            l_off   <= '0;
            l_wdata <= '0;
            cnt     <= '0;
        end else if (accept) begin
            l_write <= bus.req_write;
            l_size  <= req_size_e;
            l_uns   <= bus.req_unsigned;
            l_off   <= req_off;
            l_wdata <= bus.req_wdata;
            cnt     <= bus.req_write ? 3'(MEM_RD_LAT) : 3'(MEM_RD_LAT + 1);
        end else if (state == RD_WAIT) begin
            cnt <= cnt - 3'd1;
        end
    end

    lsu_lane u_lane (
        .rdata       (bus.mem_rdata),
        .off         (l_off),
        .size        (l_size),
        .uns         (l_uns),
        .wdata       (l_wdata),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    always_comb begin
        ready_d = (state_next == IDLE);
        valid_d = (state_next == RESP);
        we_d    = (state_next == WRITE);
        addr_d  = bus.mem_address;
        wdata_d = bus.mem_wdata;
        rdata_d = bus.resp_rdata;
        err_d   = bus.resp_err;
        if (accept) begin
            rdata_d = '0;
            err_d   = misalign;
            if (!misalign) begin
                addr_d = {3'b000, bus.req_addr[63:3]};
            end
            if (bus.req_write && (req_size_e == SZ_D)) begin
                wdata_d = bus.req_wdata;
            end
        end
        if (last_rd) begin
            if (l_write) begin
                wdata_d = merged_data;
            end else begin
                rdata_d = load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.req_ready        <= 1'b1;
            bus.resp_valid       <= 1'b0;
            bus.resp_rdata       <= '0;
            bus.resp_err         <= 1'b0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_address      <= '0;
            bus.mem_wdata        <= '0;
        end else begin
            bus.req_ready        <= ready_d;
            bus.resp_valid       <= valid_d;
            bus.resp_rdata       <= rdata_d;
            bus.resp_err         <= err_d;
            bus.mem_write_enable <= we_d;
            bus.mem_address      <= addr_d;
            bus.mem_wdata        <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu against a byte-array memory model
module tb_mem_lsu;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_clear = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   prev_done = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_lsu_if bus();

    mem_lsu #(.MEM_RD_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ram: 64 doublewords, read data valid from LAT cycles into a stable address window
    logic [63:0] ram [64];
    logic [63:0] dly [4];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 64; i++) ram[i] <= 64'd0;
        end else if (bus.mem_write_enable) begin
            ram[bus.mem_address[5:0]] <= bus.mem_wdata;
        end
        dly[0] <= ram[bus.mem_address[5:0]];
        for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end

    assign bus.mem_rdata = (LAT == 1) ? ram[bus.mem_address[5:0]] : dly[(LAT >= 2) ? LAT - 2 : 0];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [63:0] idx;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    logic [7:0] mbytes [512];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int eff_addr(input int addr, input int n);
`ifdef LSU_MISALIGN_CHECK_EN
        return addr;
`else
        return addr & ~(n - 1);
`endif
    endfunction

    function automatic logic [63:0] model_dword(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mbytes[idx*8 + i];
        return v;
    endfunction

    function automatic logic [63:0] model_load(input int sz, input logic uns, input int addr);
        int n;
        int a;
        logic [63:0] v;
        n = 1 << sz;
        a = eff_addr(addr, n);
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[a + i];
        if (sz != 3 && !uns && v[8*n - 1]) begin
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        resp_t re;
        wr_t   we;
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected no response", cyc);
            end else begin
                re = resp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, re.rdata);
                check("resp_err", 64'(bus.resp_err), 64'(re.err));
                check("resp_cycle", 64'(cyc), 64'(re.cyc));
            end
        end
        if (bus.mem_write_enable) begin
            if (wr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: mem_write_enable=1 at cycle %0d addr %h, expected no write", cyc, bus.mem_address);
            end else begin
                we = wr_q.pop_front();
                check("wr_address", bus.mem_address, we.idx);
                check("wr_data", bus.mem_wdata, we.data);
                check("wr_cycle", 64'(cyc), 64'(we.cyc));
            end
        end
    end

    // Called right after a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic w, input int sz, input logic uns, input int addr,
                         input logic [63:0] wd, input bit track);
        int k;
        int t;
        int n;
        int a;
        bit mis;
        resp_t r;
        wr_t x;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = 2'(sz);
        bus.req_unsigned = uns;
        bus.req_addr     = 64'(addr);
        bus.req_wdata    = wd;
        k = 0;
        while (!bus.req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            checks++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", k);
            bus.req_valid = 1'b0;
            return;
        end
        t = cyc;
        if (k > 0 && prev_done >= 0) check("accept_cycle", 64'(t), 64'(prev_done + 1));
        n = 1 << sz;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (addr % n) != 0;
`endif
        if (!track) begin
            prev_done = -1;
        end else begin
            if (mis) begin
                r = '{64'd0, 1'b1, t + 1};
            end else if (w) begin
                a = eff_addr(addr, n);
                for (int i = 0; i < n; i++) mbytes[a + i] = wd[8*i +: 8];
                x.idx  = 64'(a >> 3);
                x.data = model_dword(a >> 3);
                x.cyc  = (sz == 3) ? t + 1 : t + 1 + LAT;
                wr_q.push_back(x);
                r = '{64'd0, 1'b0, x.cyc + 1};
            end else begin
                r = '{model_load(sz, uns, addr), 1'b0, t + 2 + LAT};
            end
            resp_q.push_back(r);
            prev_done = r.cyc;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int gap;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        for (int i = 0; i < 512; i++) mbytes[i] = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_mem_we", 64'(bus.mem_write_enable), 64'd0);
        check("rst_mem_address", bus.mem_address, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        reset = 1'b0;
        ram_clear = 1'b0;
        @(negedge clk);

        issue(1'b1, 3, 1'b0, 'h20, 64'h1122334455667788, 1'b1);
        issue(1'b0, 3, 1'b0, 'h20, 64'd0, 1'b1);
        issue(1'b1, 0, 1'b0, 'h23, 64'h00000000000000AA, 1'b1);
        issue(1'b0, 3, 1'b1, 'h20, 64'd0, 1'b1);
        issue(1'b1, 3, 1'b0, 'h20, 64'h000000008000FF80, 1'b1);
        issue(1'b0, 0, 1'b0, 'h20, 64'd0, 1'b1);
        issue(1'b0, 0, 1'b1, 'h20, 64'd0, 1'b1);
        issue(1'b0, 1, 1'b0, 'h22, 64'd0, 1'b1);
        issue(1'b0, 2, 1'b1, 'h20, 64'd0, 1'b1);
        issue(1'b0, 2, 1'b0, 'h22, 64'd0, 1'b1);
        issue(1'b1, 2, 1'b0, 'h26, 64'hDEADBEEFCAFEF00D, 1'b1);
        issue(1'b0, 3, 1'b0, 'h20, 64'd0, 1'b1);

        // reset lands in the first RD_WAIT cycle of an untracked byte store
        issue(1'b1, 0, 1'b0, 'h21, 64'h55, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_mem_we", 64'(bus.mem_write_enable), 64'd0);
        reset = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        issue(1'b0, 3, 1'b0, 'h20, 64'd0, 1'b1);

        for (int j = 0; j < 150; j++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 511)), {$urandom, $urandom}, 1'b1);
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (gap) @(negedge clk);
        end

        for (int i = 0; i < 200 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) check($sformatf("ram_dword_%0d", i), ram[i], model_dword(i));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
